// File: rtl/alarm_trigger_pkg.sv
// Shared state encodings and default timing constants for the beep path.
// Imported by alarm_trigger and by any block that needs the same timing.
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam int RETRIG_S_D       = 2;
  localparam int RING_TIMEOUT_S_D = 60;
  localparam int SNOOZE_S_D       = 300;
  localparam int MAX_SNOOZE_D     = 3;
  localparam int CNT_W_D          = 9;

endpackage

// File: rtl/alarm_trigger_sec_timer.sv
// sec_timer: tick-driven saturating up counter with sync clear and terminal flag.
// Ports: clk, rst (async high), i_tick, i_clr, o_term (count == TERM).
module sec_timer #(
  parameter int CNT_W = 9,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_term
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick && (r_cnt != TERM_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == TERM_C);

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm ring/retrigger/timeout, snooze, stop and hourly chime;
// emits one-cycle trig pulses. Ports: clk, rst, tick_1hz, cur_*, alarm_*,
// chime_en, stop_btn, snooze_btn -> trig, ringing, snoozing (all registered).
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int RETRIG_S       = RETRIG_S_D,
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_D,
  parameter int SNOOZE_S       = SNOOZE_S_D,
  parameter int MAX_SNOOZE     = MAX_SNOOZE_D,
  parameter int CNT_W          = CNT_W_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       chime_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       trig,
  output logic       ringing,
  output logic       snoozing
);

  localparam logic [CNT_W-1:0] MAX_SNZ_C = CNT_W'(MAX_SNOOZE);

  state_t           r_state;
  state_t           w_nxt;
  logic             r_trig;
  logic             r_ringing;
  logic             r_snoozing;
  logic [CNT_W-1:0] r_snz_cnt;
  logic [CNT_W-1:0] w_snz_cnt;
  logic             w_trig;

  logic w_match;
  logic w_chime;
  logic w_ring_term;
  logic w_rtg_term;
  logic w_snz_term;
  logic w_ring_clr;
  logic w_rtg_clr;
  logic w_snz_clr;

  assign w_match = tick_1hz && alarm_en && (cur_sec == 6'd0)
                && (cur_min == alarm_min)
                && (cur_hour == alarm_hour);
  assign w_chime = tick_1hz && chime_en && (cur_sec == 6'd0)
                && (cur_min == 6'd0);

  // Timers are held at zero outside their own state, so every entry
  // into RING or SNOOZE starts from a cleared count.
  assign w_ring_clr = (r_state != ST_RING);
  assign w_rtg_clr  = (r_state != ST_RING) || (tick_1hz && w_rtg_term);
  assign w_snz_clr  = (r_state != ST_SNOOZE);

  sec_timer #(.CNT_W(CNT_W), .TERM(RING_TIMEOUT_S - 1)) u_ring (
    .clk   (clk),
    .rst   (rst),
    .i_tick(tick_1hz),
    .i_clr (w_ring_clr),
    .o_term(w_ring_term)
  );

  sec_timer #(.CNT_W(CNT_W), .TERM(RETRIG_S - 1)) u_rtg (
    .clk   (clk),
    .rst   (rst),
    .i_tick(tick_1hz),
    .i_clr (w_rtg_clr),
    .o_term(w_rtg_term)
  );

  sec_timer #(.CNT_W(CNT_W), .TERM(SNOOZE_S - 1)) u_snz (
    .clk   (clk),
    .rst   (rst),
    .i_tick(tick_1hz),
    .i_clr (w_snz_clr),
    .o_term(w_snz_term)
  );

  always_comb begin
    w_nxt     = r_state;
    w_trig    = 1'b0;
    w_snz_cnt = r_snz_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_nxt     = ST_RING;
          w_trig    = 1'b1;
          w_snz_cnt = '0;
        end else if (w_chime) begin
          w_trig = 1'b1;
        end
      end
      ST_RING: begin
        // Timeout wins over snooze and retrigger; an accepted snooze
        // suppresses a coincident retrigger pulse.
        if (tick_1hz && w_ring_term) begin
          w_nxt = ST_IDLE;
        end else if (snooze_btn && (r_snz_cnt < MAX_SNZ_C)) begin
          w_nxt     = ST_SNOOZE;
          w_snz_cnt = r_snz_cnt + 1'b1;
        end else if (tick_1hz && w_rtg_term) begin
          w_trig = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (tick_1hz && w_snz_term) begin
          w_nxt  = ST_RING;
          w_trig = 1'b1;
        end
      end
      default: begin
        w_nxt = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && !alarm_en) begin
      w_nxt  = ST_IDLE;
      w_trig = 1'b0;
    end
    if (stop_btn) begin
      w_nxt  = ST_IDLE;
      w_trig = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_trig     <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_snz_cnt  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_trig     <= w_trig;
      r_ringing  <= (w_nxt == ST_RING);
      r_snoozing <= (w_nxt == ST_SNOOZE);
      r_snz_cnt  <= w_snz_cnt;
    end
  end

  assign trig     = r_trig;
  assign ringing  = r_ringing;
  assign snoozing = r_snoozing;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: directed seconds-level stimulus, trig
// expectations queued by the driver and matched by a monitor.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hour = 5'd7;
  logic [5:0] alarm_min = 6'd30;
  logic       chime_en = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       trig;
  logic       ringing;
  logic       snoozing;

  typedef struct {
    int cyc;
    bit ring;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   hh = 0;
  int   mm = 0;
  int   ss = 0;

  alarm_trigger #(
    .RETRIG_S(2),
    .RING_TIMEOUT_S(6),
    .SNOOZE_S(4),
    .MAX_SNOOZE(1),
    .CNT_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_1hz(tick_1hz),
    .cur_hour(cur_hour),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .alarm_en(alarm_en),
    .alarm_hour(alarm_hour),
    .alarm_min(alarm_min),
    .chime_en(chime_en),
    .stop_btn(stop_btn),
    .snooze_btn(snooze_btn),
    .trig(trig),
    .ringing(ringing),
    .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every trig must match the head of the queue; an expected
  // trig whose cycle has passed is reported as missing.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t m;
      m = q.pop_front();
      checks++;
      failures++;
      $display("FAIL trig_missing: expected at cyc %0d, no trig by cyc %0d",
               m.cyc, cyc);
    end
    if (trig) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL trig_unexpected: trig=1 at cyc %0d, required none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.ring != ringing) begin
          failures++;
          $display("FAIL trig_match: got cyc %0d ringing %0b, required cyc %0d ringing %0b",
                   cyc, ringing, e.cyc, e.ring);
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b", name, got, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hh = h;
    mm = m;
    ss = s;
  endtask

  // One second: advance the clock time, strobe tick (optionally with
  // buttons in the same cycle), then idle out the rest of the period.
  task automatic sec(input bit et, input bit er,
                     input bit stp = 0, input bit snz = 0);
    ss++;
    if (ss == 60) begin
      ss = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        hh = (hh + 1) % 24;
      end
    end
    @(posedge clk);
    #1;
    cur_hour = 5'(hh);
    cur_min = 6'(mm);
    cur_sec = 6'(ss);
    tick_1hz = 1'b1;
    stop_btn = stp;
    snooze_btn = snz;
    if (et) q.push_back('{cyc + 1, er});
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic btn(input bit stp, input bit snz);
    @(posedge clk);
    #1;
    stop_btn = stp;
    snooze_btn = snz;
    @(posedge clk);
    #1;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_trig", trig, 1'b0);
    chk("reset_ringing", ringing, 1'b0);
    chk("reset_snoozing", snoozing, 1'b0);
    rst = 1'b0;

    // 1: match, retrigger at +2/+4, timeout at +6
    alarm_en = 1'b1;
    set_time(7, 29, 58);
    sec(0, 0);
    sec(1, 1);
    chk("t1_ringing", ringing, 1'b1);
    sec(0, 1);
    sec(1, 1);
    sec(0, 1);
    sec(1, 1);
    sec(0, 1);
    chk("t1_still_ringing", ringing, 1'b1);
    sec(0, 0);
    chk("t1_timeout_idle", ringing, 1'b0);

    // 2: snooze for 4 s, re-ring, second snooze ignored
    alarm_min = 6'd40;
    set_time(7, 39, 59);
    sec(1, 1);
    btn(0, 1);
    chk("t2_snoozing", snoozing, 1'b1);
    chk("t2_not_ringing", ringing, 1'b0);
    sec(0, 0);
    sec(0, 0);
    sec(0, 0);
    chk("t2_still_snoozing", snoozing, 1'b1);
    sec(1, 1);
    chk("t2_rering", ringing, 1'b1);
    btn(0, 1);
    chk("t2_snooze_limit_snz", snoozing, 1'b0);
    chk("t2_snooze_limit_ring", ringing, 1'b1);
    sec(0, 1);
    sec(1, 1);

    // 3: stop coincident with a retrigger tick
    sec(0, 1);
    sec(0, 0, 1, 0);
    chk("t3_stop_ringing", ringing, 1'b0);
    sec(0, 0);
    sec(0, 0);

    // 4: chime alone, then alarm+chime at 12:00 -> one trig, RING
    alarm_en = 1'b0;
    chime_en = 1'b1;
    alarm_hour = 5'd12;
    alarm_min = 6'd0;
    set_time(11, 59, 59);
    sec(1, 0);
    chk("t4_chime_idle", ringing, 1'b0);
    sec(0, 0);
    alarm_en = 1'b1;
    set_time(11, 59, 59);
    sec(1, 1);
    chk("t4_match_chime_ring", ringing, 1'b1);

    // 5: alarm_en dropped during SNOOZE, later chime alone
    btn(0, 1);
    chk("t5_snoozing", snoozing, 1'b1);
    @(posedge clk);
    #1;
    alarm_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_dis_snoozing", snoozing, 1'b0);
    chk("t5_dis_ringing", ringing, 1'b0);
    set_time(11, 59, 59);
    sec(1, 0);
    chk("t5_chime_idle", ringing, 1'b0);

    // 6: async reset while trig is high mid-ring
    alarm_en = 1'b1;
    chime_en = 1'b0;
    set_time(11, 59, 59);
    sec(1, 1);
    sec(0, 1);
    ss++;
    @(posedge clk);
    #1;
    cur_sec = 6'(ss);
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    chk("t6_trig_pre_rst", trig, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_trig", trig, 1'b0);
    chk("t6_rst_ringing", ringing, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) sec(0, 0);
    chk("t6_stays_idle", ringing, 1'b0);

    repeat (5) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
